// File: rtl/ga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ga_pkg
// Description : Shared widths, types, FSM encoding and the most-negative
//               fitness constant for the GA fitness evaluation slice.
// Revision    : 1.0 - initial release
// ============================================================================
package ga_pkg;
  localparam int DEFAULT_CHROM_W = 8;
  localparam int DEFAULT_FIT_W   = 27;

  typedef logic        [DEFAULT_CHROM_W-1:0] chrom_t;
  typedef logic signed [DEFAULT_FIT_W-1:0]   fit_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam fit_t FIT_MIN = {1'b1, {(DEFAULT_FIT_W-1){1'b0}}};
endpackage
`default_nettype wire

// File: rtl/fitness_eval_ctrl_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fitness_tag_pipe
// Description : Valid + pair-index shift register matching the fitness
//               function latency, so returning results find their pair.
// Revision    : 1.0 - initial release
// ============================================================================
module fitness_tag_pipe #(
  parameter int DEPTH = 1,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_valid_i,
  input  logic [IDX_W-1:0] push_idx_i,
  output logic             out_valid_o,
  output logic [IDX_W-1:0] out_idx_o
);
  logic             valid_q [DEPTH];
  logic [IDX_W-1:0] idx_q   [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < DEPTH; s++) begin
        valid_q[s] <= 1'b0;
        idx_q[s]   <= '0;
      end
    end else begin
      valid_q[0] <= push_valid_i;
      idx_q[0]   <= push_idx_i;
      for (int s = 1; s < DEPTH; s++) begin
        valid_q[s] <= valid_q[s-1];
        idx_q[s]   <= idx_q[s-1];
      end
    end
  end

  assign out_valid_o = valid_q[DEPTH-1];
  assign out_idx_o   = idx_q[DEPTH-1];
endmodule
`default_nettype wire

// File: rtl/fitness_eval_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fitness_eval_ctrl
// Description : Streams a snapshotted population pairwise through the
//               two-lane fitness pipeline and collects the fitness file.
//               Optional running-argmax: define FITNESS_EVAL_BEST_TRACK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fitness_eval_ctrl
  import ga_pkg::*;
#(
  parameter int POP_SIZE   = 16,
  parameter int CHROM_W    = DEFAULT_CHROM_W,
  parameter int FIT_W      = DEFAULT_FIT_W,
  parameter int FF_LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [POP_SIZE*CHROM_W-1:0] pop_in,
  output logic [CHROM_W-1:0]        ff_chrom1,
  output logic [CHROM_W-1:0]        ff_chrom2,
  input  logic signed [FIT_W-1:0]   ff_fitness1,
  input  logic signed [FIT_W-1:0]   ff_fitness2,
  output logic [POP_SIZE*FIT_W-1:0] fit_out,
  output logic                      busy,
  output logic                      done,
  output logic [7:0]                best_index,
  output logic signed [FIT_W-1:0]   best_fitness
);
  localparam int PAIRS = POP_SIZE / 2;
  localparam int IDX_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam logic [IDX_W-1:0] LAST_PAIR = IDX_W'(PAIRS - 1);
  localparam logic signed [FIT_W-1:0] FIT_LOW = {1'b1, {(FIT_W-1){1'b0}}};

  state_t state_q, state_d;
  logic [CHROM_W-1:0]      snap_q [POP_SIZE];
  logic signed [FIT_W-1:0] fit_q  [POP_SIZE];
  logic [IDX_W-1:0]        issue_cnt_q;
  logic [IDX_W-1:0]        next_pair;
  logic [CHROM_W-1:0]      chrom1_q, chrom2_q;
  logic                    tag_valid;
  logic [IDX_W-1:0]        tag_idx;
  logic                    start_run;

  assign start_run = (state_q == IDLE) && start;
  assign next_pair = issue_cnt_q + IDX_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE:  if (start) state_d = ISSUE;
      ISSUE: begin
        busy = 1'b1;
        if (issue_cnt_q == LAST_PAIR) state_d = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (tag_valid && (tag_idx == LAST_PAIR)) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pair 0 is loaded straight from pop_in on the start edge so it is
  // presented in the very first ISSUE cycle; later pairs come from the snapshot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < POP_SIZE; i++) snap_q[i] <= '0;
      issue_cnt_q <= '0;
      chrom1_q    <= '0;
      chrom2_q    <= '0;
    end else if (start_run) begin
      for (int i = 0; i < POP_SIZE; i++) snap_q[i] <= pop_in[i*CHROM_W +: CHROM_W];
      issue_cnt_q <= '0;
      chrom1_q    <= pop_in[0 +: CHROM_W];
      chrom2_q    <= pop_in[CHROM_W +: CHROM_W];
    end else if ((state_q == ISSUE) && (issue_cnt_q != LAST_PAIR)) begin
      issue_cnt_q <= next_pair;
      chrom1_q    <= snap_q[{next_pair, 1'b0}];
      chrom2_q    <= snap_q[{next_pair, 1'b1}];
    end
  end

  assign ff_chrom1 = chrom1_q;
  assign ff_chrom2 = chrom2_q;

  fitness_tag_pipe #(
    .DEPTH (FF_LATENCY),
    .IDX_W (IDX_W)
  ) u_tag_pipe (
    .clk          (clk),
    .reset        (reset),
    .push_valid_i (state_q == ISSUE),
    .push_idx_i   (issue_cnt_q),
    .out_valid_o  (tag_valid),
    .out_idx_o    (tag_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < POP_SIZE; i++) fit_q[i] <= '0;
    end else if (tag_valid) begin
      fit_q[{tag_idx, 1'b0}] <= ff_fitness1;
      fit_q[{tag_idx, 1'b1}] <= ff_fitness2;
    end
  end

  for (genvar i = 0; i < POP_SIZE; i++) begin : g_fit
    assign fit_out[i*FIT_W +: FIT_W] = fit_q[i];
  end

`ifdef FITNESS_EVAL_BEST_TRACK_EN
  logic                    odd_wins;
  logic signed [FIT_W-1:0] win_fit;
  logic [7:0]              win_idx;
  logic [7:0]              best_idx_q;
  logic signed [FIT_W-1:0] best_fit_q;

  // Strict compares keep the lowest index on ties, within and across pairs.
  assign odd_wins = ff_fitness2 > ff_fitness1;
  assign win_fit  = odd_wins ? ff_fitness2 : ff_fitness1;
  assign win_idx  = 8'({tag_idx, odd_wins});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      best_idx_q <= '0;
      best_fit_q <= FIT_LOW;
    end else if (start_run) begin
      best_idx_q <= '0;
      best_fit_q <= FIT_LOW;
    end else if (tag_valid && (win_fit > best_fit_q)) begin
      best_idx_q <= win_idx;
      best_fit_q <= win_fit;
    end
  end

  assign best_index   = best_idx_q;
  assign best_fitness = best_fit_q;
`else
  assign best_index   = '0;
  assign best_fitness = '0;
`endif
endmodule
`default_nettype wire
